ifu_fetch_queue: RTL

Parametrised instruction-fetch unit that replaces the core's zero-latency combinational instruction read with a valid/ready memory request/response interface. It issues sequential fetch requests, buffers returned instructions with their PCs in a DEPTH-entry in-order queue, and delivers them to decode over a valid/ready handshake. A redirect input from branch, jump and ecall/mret resolution flushes the queue, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/ifu_fetch_queue.sv | 96 +++++++++
 1 files changed

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: sequential valid/ready fetch requests, an in-order
// instruction queue toward decode, and redirect flush with stale-response drop.
module ifu_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [XLEN-1:0]            req_addr,
  input  logic                       rsp_valid,
  input  logic [31:0]                rsp_data,
  input  logic                       rsp_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_err,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  head_pc;
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    drop;
  logic [CW:0]      used;
  logic             req_fire;
  logic             rsp_ok;
  logic             push;
  logic             pop;

  // Credit covers both buffered and outstanding words so responses never overflow
  assign used      = {1'b0, count} + {1'b0, inflight};
  assign req_valid = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign req_addr  = fetch_pc;
  assign req_fire  = req_valid && req_ready;
  assign rsp_ok    = rsp_valid && (inflight != '0);
  assign push      = rsp_ok && (drop == '0);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_pc    = head_pc;
  assign out_inst  = inst_q[rd_ptr];
  assign out_err   = err_q[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      err_q    <= '0;
      for (int i = 0; i < DEPTH; i++) inst_q[i] <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
      if (redirect_valid) begin
        // Everything still outstanding belongs to the abandoned path
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        head_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= inflight - CW'(rsp_ok);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_ok && (drop != '0)) drop <= drop - CW'(1);
        if (push) begin
          inst_q[wr_ptr] <= rsp_data;
          err_q[wr_ptr]  <= rsp_err;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          head_pc <= head_pc + XLEN'(4);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
